// File: rtl/pool_window_buffer_if.sv
// ---------------------------------------------------------------------------
// pool_window_buffer_if
// Bundles the pixel input stream and the 2x2 window output of
// pool_window_buffer.
//   in_valid   : a pixel is present this cycle (no backpressure)
//   in_sof     : pixel is (row 0, col 0) of a frame, qualified by in_valid
//   in_data    : pixel word
//   win_valid  : single-cycle pulse, win0..win3 / win_idx valid
//   win0..win3 : top-left, top-right, bottom-left, bottom-right pixels
//   win_idx    : raster index of the window within the frame
//   frame_done : pulses together with the last window of a frame
// Modports:
//   master : pixel source / window consumer (drives in_*, reads win_*)
//   slave  : the window buffer itself (reads in_*, drives win_*)
// ---------------------------------------------------------------------------
interface pool_window_buffer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 8
);
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_data;
    logic              win_valid;
    logic [DATA_W-1:0] win0;
    logic [DATA_W-1:0] win1;
    logic [DATA_W-1:0] win2;
    logic [DATA_W-1:0] win3;
    logic [IDX_W-1:0]  win_idx;
    logic              frame_done;

    modport master (
        output in_valid, in_sof, in_data,
        input  win_valid, win0, win1, win2, win3, win_idx, frame_done
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output win_valid, win0, win1, win2, win3, win_idx, frame_done
    );
endinterface

// File: rtl/pool_window_buffer.sv
// ---------------------------------------------------------------------------
// pool_window_buffer
// Feeds the 2x2 max-pooler. Accepts a raster-order pixel stream, stores each
// even row in a one-row line buffer and, on every odd-column pixel of the
// following odd row, emits the full 2x2 window with its raster window index.
// Words are never interpreted, only stored and routed.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : pool_window_buffer_if slave modport (pixel in, window out)
// ---------------------------------------------------------------------------
module pool_window_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    // A single-window frame (2x2) still needs a 1-bit index port.
    parameter int unsigned IDX_W  = (IMG_W * IMG_H / 4 > 1) ? $clog2(IMG_W * IMG_H / 4) : 1
) (
    input logic                 clk,
    input logic                 rst_n,
    pool_window_buffer_if.slave bus
);

    localparam int unsigned COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
        $error("pool_window_buffer: IMG_W must be even and >= 2");
    end
    if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
        $error("pool_window_buffer: IMG_H must be even and >= 2");
    end

    typedef enum logic [0:0] {
        StEvenRow,
        StOddRow
    } state_e;

    state_e            state_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [IDX_W-1:0]  win_cnt_q;
    logic [DATA_W-1:0] left_q;
    logic [DATA_W-1:0] linebuf_q [IMG_W];

    logic              win_valid_q;
    logic              frame_done_q;
    logic [DATA_W-1:0] win0_q;
    logic [DATA_W-1:0] win1_q;
    logic [DATA_W-1:0] win2_q;
    logic [DATA_W-1:0] win3_q;
    logic [IDX_W-1:0]  win_idx_q;

    logic             wr_en;
    logic [COL_W-1:0] wr_addr;
    logic [COL_W-1:0] rd_addr_left;
    logic             col_last;
    logic             row_last;

    always_comb begin
        // Writes only happen in even rows, reads only in odd rows, so the
        // asynchronous-read buffer never sees a same-address collision.
        wr_en        = bus.in_valid && (bus.in_sof || (state_q == StEvenRow));
        wr_addr      = bus.in_sof ? '0 : col_q;
        rd_addr_left = col_q - COL_W'(1);
        col_last     = (col_q == COL_LAST);
        row_last     = (row_q == ROW_LAST);
    end

    // Line buffer holds don't-care data after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            linebuf_q[wr_addr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEvenRow;
            col_q        <= '0;
            row_q        <= '0;
            win_cnt_q    <= '0;
            left_q       <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win0_q       <= '0;
            win1_q       <= '0;
            win2_q       <= '0;
            win3_q       <= '0;
            win_idx_q    <= '0;
        end else begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.in_valid) begin
                if (bus.in_sof) begin
                    // Restart the frame: this pixel is (0,0), already written.
                    state_q   <= StEvenRow;
                    col_q     <= COL_W'(1);
                    row_q     <= '0;
                    win_cnt_q <= '0;
                end else begin
                    unique case (state_q)
                        StEvenRow: begin
                            if (col_last) begin
                                col_q   <= '0;
                                row_q   <= row_q + ROW_W'(1);
                                state_q <= StOddRow;
                            end else begin
                                col_q <= col_q + COL_W'(1);
                            end
                        end
                        StOddRow: begin
                            if (!col_q[0]) begin
                                left_q <= bus.in_data;
                            end else begin
                                win0_q      <= linebuf_q[rd_addr_left];
                                win1_q      <= linebuf_q[col_q];
                                win2_q      <= left_q;
                                win3_q      <= bus.in_data;
                                win_idx_q   <= win_cnt_q;
                                win_valid_q <= 1'b1;
                                win_cnt_q   <= win_cnt_q + IDX_W'(1);
                            end
                            if (col_last) begin
                                col_q   <= '0;
                                state_q <= StEvenRow;
                                if (row_last) begin
                                    // Last window: overrides the increment above.
                                    row_q        <= '0;
                                    win_cnt_q    <= '0;
                                    frame_done_q <= 1'b1;
                                end else begin
                                    row_q <= row_q + ROW_W'(1);
                                end
                            end else begin
                                col_q <= col_q + COL_W'(1);
                            end
                        end
                        default: state_q <= StEvenRow;
                    endcase
                end
            end
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.win0       = win0_q;
    assign bus.win1       = win1_q;
    assign bus.win2       = win2_q;
    assign bus.win3       = win3_q;
    assign bus.win_idx    = win_idx_q;

endmodule

// File: tb/tb_pool_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_pool_window_buffer
// Drives the same pixel stream into a 4x4 and a 2x2 instance and compares
// every cycle against a frame-array reference model.
// ---------------------------------------------------------------------------
module tb_pool_window_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pool_window_buffer_if #(.DATA_W(32), .IDX_W(2)) bus4 ();
    pool_window_buffer_if #(.DATA_W(32), .IDX_W(1)) bus2 ();

    pool_window_buffer #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    pool_window_buffer #(.DATA_W(32), .IMG_W(2), .IMG_H(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int win4_cnt = 0;
    int fd4_cnt  = 0;
    int fd2_cnt  = 0;

    // Reference model: index 0 = 4x4 instance, index 1 = 2x2 instance.
    int          pos  [2];
    logic [31:0] pix  [2][16];
    logic        ev   [2];
    logic        efd  [2];
    logic [31:0] ew   [2][4];
    int          eidx [2];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int img_w(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pos[k]  = 0;
            ev[k]   = 1'b0;
            efd[k]  = 1'b0;
            eidx[k] = 0;
            for (int j = 0; j < 4; j++) ew[k][j] = '0;
        end
    endtask

    task automatic model_step(input int k, input logic v, input logic s, input logic [31:0] d);
        int w, n, r, c;
        w = img_w(k);
        n = w * w;
        ev[k]  = 1'b0;
        efd[k] = 1'b0;
        if (v) begin
            if (s) pos[k] = 0;
            r = pos[k] / w;
            c = pos[k] % w;
            pix[k][pos[k]] = d;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                ev[k]    = 1'b1;
                ew[k][0] = pix[k][pos[k] - w - 1];
                ew[k][1] = pix[k][pos[k] - w];
                ew[k][2] = pix[k][pos[k] - 1];
                ew[k][3] = d;
                eidx[k]  = (r / 2) * (w / 2) + (c / 2);
                efd[k]   = (pos[k] == n - 1);
            end
            pos[k] = (pos[k] + 1) % n;
        end
    endtask

    task automatic check_dut(input int k, input logic v, input logic fd, input logic [31:0] w0,
                             input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                             input logic [63:0] idx);
        string p;
        p = (k == 0) ? "4x4" : "2x2";
        check_eq($sformatf("%s win_valid", p), 64'(v), 64'(ev[k]));
        check_eq($sformatf("%s frame_done", p), 64'(fd), 64'(efd[k]));
        check_eq($sformatf("%s win0", p), 64'(w0), 64'(ew[k][0]));
        check_eq($sformatf("%s win1", p), 64'(w1), 64'(ew[k][1]));
        check_eq($sformatf("%s win2", p), 64'(w2), 64'(ew[k][2]));
        check_eq($sformatf("%s win3", p), 64'(w3), 64'(ew[k][3]));
        check_eq($sformatf("%s win_idx", p), idx, 64'(eidx[k]));
    endtask

    task automatic check_outputs();
        check_dut(0, bus4.win_valid, bus4.frame_done, bus4.win0, bus4.win1, bus4.win2,
                  bus4.win3, 64'(bus4.win_idx));
        check_dut(1, bus2.win_valid, bus2.frame_done, bus2.win0, bus2.win1, bus2.win2,
                  bus2.win3, 64'(bus2.win_idx));
    endtask

    task automatic step(input logic v, input logic s, input logic [31:0] d);
        bus4.in_valid = v;
        bus4.in_sof   = s;
        bus4.in_data  = d;
        bus2.in_valid = v;
        bus2.in_sof   = s;
        bus2.in_data  = d;
        model_step(0, v, s, d);
        model_step(1, v, s, d);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        if (bus4.win_valid === 1'b1) win4_cnt++;
        if (bus4.frame_done === 1'b1) fd4_cnt++;
        if (bus2.frame_done === 1'b1) fd2_cnt++;
    endtask

    // Idle cycles carry random in_sof/in_data, which must be ignored.
    task automatic idle_gap(input int max_len);
        int ng;
        ng = $urandom_range(0, max_len);
        for (int g = 0; g < ng; g++) step(1'b0, 1'($urandom_range(0, 1)), $urandom);
    endtask

    task automatic send_frame(input logic [31:0] base, input bit gaps, input bit rnd);
        for (int i = 0; i < 16; i++) begin
            if (gaps) idle_gap(3);
            step(1'b1, (i == 0), rnd ? $urandom : base + 32'(i));
        end
    endtask

    task automatic pulse_reset();
        bus4.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus4.in_valid = 1'b0;
        bus4.in_sof   = 1'b0;
        bus4.in_data  = '0;
        bus2.in_valid = 1'b0;
        bus2.in_sof   = 1'b0;
        bus2.in_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Back-to-back frame 0..15.
        win4_cnt = 0; fd4_cnt = 0; fd2_cnt = 0;
        send_frame(32'd0, 1'b0, 1'b0);
        check_eq("frame1 4x4 window count", 64'(win4_cnt), 64'd4);
        check_eq("frame1 4x4 frame_done count", 64'(fd4_cnt), 64'd1);
        check_eq("frame1 2x2 frame_done count", 64'(fd2_cnt), 64'd4);
        check_eq("frame1 last win0", 64'(bus4.win0), 64'd10);
        check_eq("frame1 last win3", 64'(bus4.win3), 64'd15);
        check_eq("frame1 last idx", 64'(bus4.win_idx), 64'd3);

        // Same frame with idle gaps.
        win4_cnt = 0;
        send_frame(32'd0, 1'b1, 1'b0);
        check_eq("gapped 4x4 window count", 64'(win4_cnt), 64'd4);

        // Two consecutive frames, no gap.
        fd4_cnt = 0;
        send_frame(32'd200, 1'b0, 1'b0);
        send_frame(32'd300, 1'b0, 1'b0);
        check_eq("two frames frame_done count", 64'(fd4_cnt), 64'd2);

        // in_sof on word 9 abandons the partial frame.
        win4_cnt = 0; fd4_cnt = 0;
        for (int i = 0; i < 9; i++) step(1'b1, (i == 0), 32'(i));
        send_frame(32'd100, 1'b0, 1'b0);
        check_eq("sof restart window count", 64'(win4_cnt), 64'd6);
        check_eq("sof restart frame_done count", 64'(fd4_cnt), 64'd1);

        // Reset after word 6, then a frame without in_sof.
        for (int i = 0; i < 7; i++) step(1'b1, (i == 0), 32'(i));
        pulse_reset();
        win4_cnt = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'd400 + 32'(i));
        check_eq("post-reset window count", 64'(win4_cnt), 64'd4);

        // Random frames with gaps, then a fully random stream with stray sofs.
        repeat (4) send_frame(32'd0, 1'b1, 1'b1);
        repeat (200) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), $urandom);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_window_buffer.md
Name: pool_window_buffer

Overview:
- Upstream feeder for the 2x2 max-pooling stage in every layer.
- Takes a raster-order stream of 32-bit FP32 feature-map pixels, one pixel per accepted beat.
- Buffers one even row and emits a complete 2x2 window (four words) on the pooler's data_in0..data_in3 inputs.
- Data-agnostic: words are never interpreted, only stored and routed.

Parameters:
- DATA_W, 32, pixel word width.
- IMG_W, 28, feature-map width in pixels; must be even and >= 2.
- IMG_H, 28, feature-map height in rows; must be even and >= 2.
- IDX_W, $clog2(IMG_W*IMG_H/4), width of the window index.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset: asynchronous, active-low.
- in_valid  input  1  in_data carries a pixel this cycle; always accepted, no ready signal.
- in_sof  input  1  qualified by in_valid; marks pixel (row 0, col 0) of a frame.
- in_data  input  DATA_W  pixel word.
- win_valid  output  1  win0..win3 and win_idx are valid this cycle (single-cycle pulse).
- win0  output  DATA_W  top-left pixel (row r-1, col c-1).
- win1  output  DATA_W  top-right pixel (row r-1, col c).
- win2  output  DATA_W  bottom-left pixel (row r, col c-1).
- win3  output  DATA_W  bottom-right pixel (row r, col c).
- win_idx  output  IDX_W  raster index of the window within the frame: (r/2)*(IMG_W/2)+(c/2).
- frame_done  output  1  one-cycle pulse coincident with the win_valid of the last window of a frame.

Behaviour:
- Reset values, asynchronous on rst_n low: win_valid=0, frame_done=0, win0..win3=0, win_idx=0.
- Also reset to 0: col counter, row counter, window counter and the left-pixel register; state=EVEN_ROW.
- Line buffer RAM (IMG_W x DATA_W) is not reset; its contents are don't-care.
- Accept: a beat is consumed only when in_valid=1. Idle gaps of any length are allowed; counters and state hold during gaps.
- Counters: col runs 0..IMG_W-1 and wraps to 0. On wrap, row increments; row wraps from IMG_H-1 to 0.
- State EVEN_ROW (row even):
  - Write in_data to linebuf[col]. No output.
  - At col=IMG_W-1, go to ODD_ROW.
- State ODD_ROW (row odd), on col even:
  - Capture in_data into the left register.
- State ODD_ROW, on col odd, register outputs on the same edge:
  - win0=linebuf[col-1], win1=linebuf[col], win2=left register, win3=in_data.
  - win_idx=window counter; win_valid=1. Window counter then increments.
- State ODD_ROW, at col=IMG_W-1:
  - If row=IMG_H-1: assert frame_done with that window, clear the window counter and row, go to EVEN_ROW.
  - Otherwise go to EVEN_ROW.
- Latency: win_valid rises the cycle after the edge that accepts the bottom-right pixel. Outputs are held until the next window; win_valid and frame_done are deasserted on any cycle without a new window.
- Throughput: one window per two accepted odd-row pixels; IMG_W*IMG_H/4 windows per frame.
- in_sof with in_valid:
  - Forces the pixel to be treated as (row 0, col 0): written to linebuf[0], col=1, row=0, window counter=0, state EVEN_ROW.
  - Any partial frame is abandoned with no window or frame_done emitted for it.
- in_sof at (0,0) in normal flow: no effect beyond normal processing.
- Mid-frame reset: all state is cleared and the partial frame is dropped. The next frame begins at the first accepted pixel after rst_n deasserts, with or without in_sof.
- Linebuf read and write of the same address never coincide, since reads occur only in ODD_ROW. A synchronous-read RAM may be used only if output timing is preserved; otherwise use registers or an asynchronous-read RAM.
- Elaboration error if IMG_W or IMG_H is odd.

Test Plan:
- IMG_W=4, IMG_H=4, raw words 0..15 streamed back-to-back with in_sof on word 0 -> windows (0,1,4,5) idx0, (2,3,6,7) idx1, (8,9,12,13) idx2, (10,11,14,15) idx3. Each window appears one cycle after words 5, 7, 13 and 15. frame_done only with idx3.
- Same frame with in_valid toggling 1,0,0,1 pseudo-randomly -> identical windows and idx sequence; win_valid count=4; no window during gaps.
- Two consecutive frames, no gap -> second frame windows again idx0..3, with values offset by the second frame's data. frame_done pulses twice.
- in_sof asserted on word 9 of a frame (data 100..) -> no window for the abandoned frame beyond those already emitted. Word 100 is treated as (0,0) and a full 16-word frame yields idx0..3.
- rst_n pulsed low after word 6 -> all outputs 0 immediately. The next 16 words yield four correct windows starting at idx0.
- IMG_W=2, IMG_H=2, words A,B,C,D -> a single window (A,B,C,D) with idx0 and frame_done high in the same cycle.
